// File: rtl/maze_path_player_if.sv
// Move port between the maze path player and the display/LED stage.
//   move_valid : producer has a move on move_x/move_y/move_dir
//   move_ready : consumer accepts the move when move_valid & move_ready
//   move_x     : x of cell after the move
//   move_y     : y of cell after the move
//   move_dir   : direction just applied (00 up, 01 right, 10 left, 11 down)
// master = player (producer), slave = display stage (consumer).
interface maze_path_player_if #(
    parameter int COORD_W = 4
) ();
    logic               move_valid;
    logic               move_ready;
    logic [COORD_W-1:0] move_x;
    logic [COORD_W-1:0] move_y;
    logic [1:0]         move_dir;

    modport master (
        output move_valid,
        output move_x,
        output move_y,
        output move_dir,
        input  move_ready
    );

    modport slave (
        input  move_valid,
        input  move_x,
        input  move_y,
        input  move_dir,
        output move_ready
    );
endinterface

// File: rtl/maze_path_player.sv
// Playback stage for the maze solver. Each read_checkList request pops one
// direction from the checkList store, turns it into the next absolute (x,y)
// cell starting from (0,0), offers it on the move port and then pulses
// finished_reading back to the controller.
// Ports:
//   clk, rst_n       : clock, synchronous active-low reset
//   init             : synchronous clear of position/counters/sticky flags
//   read_checkList   : request level, held until finished_reading
//   cl_empty         : checkList store empty
//   cl_dir           : head direction, valid the cycle after cl_pop
//   cl_pop           : pop one entry from the store
//   finished_reading : 1-cycle service acknowledge
//   move_if          : move port (valid/ready + x, y, dir)
//   step_count       : moves accepted since init, saturating
//   path_end         : sticky, a request found the store empty
//   move_err         : sticky, a move would have left the grid
module maze_path_player #(
    parameter int COORD_W = 4,
    parameter int STEP_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  init,
    input  logic                  read_checkList,
    input  logic                  cl_empty,
    input  logic [1:0]            cl_dir,
    output logic                  cl_pop,
    output logic                  finished_reading,
    maze_path_player_if.master    move_if,
    output logic [STEP_W-1:0]     step_count,
    output logic                  path_end,
    output logic                  move_err
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_LATCH   = 3'd2,
        S_PRESENT = 3'd3,
        S_ACK     = 3'd4,
        S_WAIT    = 3'd5
    } state_t;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_DOWN  = 2'b11;

    state_t             state_q, state_d;
    logic [COORD_W-1:0] pos_x_q, pos_x_d;
    logic [COORD_W-1:0] pos_y_q, pos_y_d;
    logic [COORD_W-1:0] move_x_q, move_x_d;
    logic [COORD_W-1:0] move_y_q, move_y_d;
    logic [1:0]         move_dir_q, move_dir_d;
    logic [STEP_W-1:0]  step_q, step_d;
    logic               path_end_q, path_end_d;
    logic               move_err_q, move_err_d;

    logic [COORD_W-1:0] next_x;
    logic [COORD_W-1:0] next_y;
    logic               off_grid;

    // Candidate cell for the direction on cl_dir; only meaningful in LATCH.
    always_comb begin
        next_x   = pos_x_q;
        next_y   = pos_y_q;
        off_grid = 1'b0;
        unique case (cl_dir)
            DIR_UP: begin
                off_grid = (pos_y_q == '0);
                next_y   = pos_y_q - COORD_W'(1);
            end
            DIR_RIGHT: begin
                off_grid = (pos_x_q == '1);
                next_x   = pos_x_q + COORD_W'(1);
            end
            DIR_LEFT: begin
                off_grid = (pos_x_q == '0);
                next_x   = pos_x_q - COORD_W'(1);
            end
            DIR_DOWN: begin
                off_grid = (pos_y_q == '1);
                next_y   = pos_y_q + COORD_W'(1);
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        pos_x_d    = pos_x_q;
        pos_y_d    = pos_y_q;
        move_x_d   = move_x_q;
        move_y_d   = move_y_q;
        move_dir_d = move_dir_q;
        step_d     = step_q;
        path_end_d = path_end_q;
        move_err_d = move_err_q;

        case (state_q)
            S_IDLE: begin
                if (read_checkList) begin
                    if (cl_empty) begin
                        path_end_d = 1'b1;
                        state_d    = S_ACK;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end
            S_FETCH: state_d = S_LATCH;
            S_LATCH: begin
                move_dir_d = cl_dir;
                if (off_grid) begin
                    // Blocked move: flag it, keep position, still present it.
                    move_err_d = 1'b1;
                    move_x_d   = pos_x_q;
                    move_y_d   = pos_y_q;
                end else begin
                    pos_x_d  = next_x;
                    pos_y_d  = next_y;
                    move_x_d = next_x;
                    move_y_d = next_y;
                end
                state_d = S_PRESENT;
            end
            S_PRESENT: begin
                if (move_if.move_ready) begin
                    if (step_q != '1) begin
                        step_d = step_q + STEP_W'(1);
                    end
                    state_d = S_ACK;
                end
            end
            S_ACK: state_d = S_WAIT;
            S_WAIT: begin
                if (!read_checkList) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // init overrides whatever the FSM decided this cycle.
        if (init) begin
            state_d    = S_IDLE;
            pos_x_d    = '0;
            pos_y_d    = '0;
            step_d     = '0;
            path_end_d = 1'b0;
            move_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pos_x_q    <= '0;
            pos_y_q    <= '0;
            move_x_q   <= '0;
            move_y_q   <= '0;
            move_dir_q <= '0;
            step_q     <= '0;
            path_end_q <= 1'b0;
            move_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pos_x_q    <= pos_x_d;
            pos_y_q    <= pos_y_d;
            move_x_q   <= move_x_d;
            move_y_q   <= move_y_d;
            move_dir_q <= move_dir_d;
            step_q     <= step_d;
            path_end_q <= path_end_d;
            move_err_q <= move_err_d;
        end
    end

    assign cl_pop             = (state_q == S_FETCH);
    assign finished_reading   = (state_q == S_ACK);
    assign move_if.move_valid = (state_q == S_PRESENT);
    assign move_if.move_x     = move_x_q;
    assign move_if.move_y     = move_y_q;
    assign move_if.move_dir   = move_dir_q;
    assign step_count         = step_q;
    assign path_end           = path_end_q;
    assign move_err           = move_err_q;

endmodule

// File: tb/tb_maze_path_player.sv
module tb_maze_path_player;

    localparam int COORD_W = 4;
    localparam int STEP_W  = 8;
    localparam int MAXC    = (1 << COORD_W) - 1;
    localparam int MAXS    = (1 << STEP_W) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic init = 1'b0;
    logic read_checkList = 1'b0;
    logic cl_empty = 1'b1;
    logic [1:0] cl_dir = 2'b00;
    logic cl_pop;
    logic finished_reading;
    logic [STEP_W-1:0] step_count;
    logic path_end;
    logic move_err;

    maze_path_player_if #(.COORD_W(COORD_W)) mv_if ();

    maze_path_player #(.COORD_W(COORD_W), .STEP_W(STEP_W)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .init             (init),
        .read_checkList   (read_checkList),
        .cl_empty         (cl_empty),
        .cl_dir           (cl_dir),
        .cl_pop           (cl_pop),
        .finished_reading (finished_reading),
        .move_if          (mv_if.master),
        .step_count       (step_count),
        .path_end         (path_end),
        .move_err         (move_err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors = vectors + 1;
        if (act !== exp) begin
            miscompares = miscompares + 1;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (grid walk) ----------------
    typedef struct {
        int x;
        int y;
        int d;
        int err;
        int st;
    } mv_t;

    mv_t exp_q[$];
    int  m_x = 0, m_y = 0, m_err = 0, m_pe = 0, m_step = 0;
    int  exp_pops = 0;

    function automatic void model_clear();
        m_x = 0; m_y = 0; m_err = 0; m_pe = 0; m_step = 0;
        exp_q.delete();
    endfunction

    function automatic void model_move(input int d);
        int nx, ny;
        mv_t e;
        nx = m_x; ny = m_y;
        if (d == 0) ny = m_y - 1;
        else if (d == 1) nx = m_x + 1;
        else if (d == 2) nx = m_x - 1;
        else ny = m_y + 1;
        if (nx < 0 || nx > MAXC || ny < 0 || ny > MAXC) m_err = 1;
        else begin m_x = nx; m_y = ny; end
        m_step = (m_step < MAXS) ? m_step + 1 : MAXS;
        e.x = m_x; e.y = m_y; e.d = d; e.err = m_err; e.st = m_step;
        exp_q.push_back(e);
    endfunction

    // ---------------- checkList store ----------------
    // head_dir appears on cl_dir only in the cycle after a pop; otherwise noise.
    logic [1:0] head_dir = 2'b00;
    int pop_cnt = 0;
    always @(posedge clk) begin
        if (cl_pop) begin
            pop_cnt = pop_cnt + 1;
            cl_dir <= head_dir;
        end else begin
            cl_dir <= 2'($urandom);
        end
    end

    // ---------------- monitor ----------------
    bit  fin_next = 0, step_next = 0, hold_pending = 0;
    int  step_exp_n = 0;
    logic [COORD_W-1:0] h_x, h_y;
    logic [1:0] h_d;

    always @(negedge clk) begin
        if (fin_next) chk("fin_after_accept", 32'(finished_reading), 32'd1);
        if (step_next) chk("step_count", 32'(step_count), 32'(step_exp_n));
        if (hold_pending) begin
            chk("hold_valid", 32'(mv_if.move_valid), 32'd1);
            chk("hold_x", 32'(mv_if.move_x), 32'(h_x));
            chk("hold_y", 32'(mv_if.move_y), 32'(h_y));
            chk("hold_dir", 32'(mv_if.move_dir), 32'(h_d));
        end
        fin_next = 0; step_next = 0; hold_pending = 0;
        if (rst_n && !init && mv_if.move_valid) begin
            if (mv_if.move_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_move", 32'd1, 32'd0);
                end else begin
                    mv_t e;
                    e = exp_q.pop_front();
                    chk("move_x", 32'(mv_if.move_x), 32'(e.x));
                    chk("move_y", 32'(mv_if.move_y), 32'(e.y));
                    chk("move_dir", 32'(mv_if.move_dir), 32'(e.d));
                    chk("move_err", 32'(move_err), 32'(e.err));
                    step_exp_n = e.st;
                    step_next = 1;
                end
                fin_next = 1;
            end else begin
                hold_pending = 1;
                h_x = mv_if.move_x; h_y = mv_if.move_y; h_d = mv_if.move_dir;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full request. hold>0: keep move_ready low for hold cycles of move_valid.
    task automatic request(input bit empty, input logic [1:0] dir, input int ready_pct, input int hold);
        int cyc, lat, vcyc;
        bit done;
        cl_empty = empty;
        head_dir = dir;
        if (empty) m_pe = 1;
        else begin model_move(int'(dir)); exp_pops = exp_pops + 1; end
        read_checkList = 1'b1;
        mv_if.move_ready = (hold > 0) ? 1'b0 : 1'b1;
        lat = -1; vcyc = 0; done = 0;
        for (cyc = 1; cyc <= 60 && !done; cyc++) begin
            tick();
            if (mv_if.move_valid) begin
                if (lat < 0) lat = cyc;
                vcyc = vcyc + 1;
            end
            if (hold > 0) mv_if.move_ready = (vcyc > hold);
            else mv_if.move_ready = ($urandom_range(0, 99) < ready_pct);
            if (finished_reading) done = 1;
        end
        chk("fin_seen", 32'(done), 32'd1);
        if (!empty) chk("latency", 32'(lat), 32'd3);
        else chk("no_move_on_empty", 32'(lat), 32'hFFFF_FFFF);
        if (hold > 0) chk("hold_cycles", 32'(vcyc), 32'(hold + 1));
        tick();
        chk("fin_width", 32'(finished_reading), 32'd0);
        chk("path_end", 32'(path_end), 32'(m_pe));
        chk("pop_count", 32'(pop_cnt), 32'(exp_pops));
        read_checkList = 1'b0;
        tick();
    endtask

    task automatic do_init();
        init = 1'b1;
        tick();
        init = 1'b0;
        model_clear();
    endtask

    // Interrupt a move sitting in PRESENT with init (use_rst=0) or rst_n (use_rst=1).
    task automatic abort(input bit use_rst, input logic [1:0] dir);
        int cyc;
        cl_empty = 1'b0;
        head_dir = dir;
        exp_pops = exp_pops + 1;
        read_checkList = 1'b1;
        mv_if.move_ready = 1'b0;
        for (cyc = 0; cyc < 10 && !mv_if.move_valid; cyc++) tick();
        chk("abort_valid_seen", 32'(mv_if.move_valid), 32'd1);
        read_checkList = 1'b0;
        if (use_rst) rst_n = 1'b0; else init = 1'b1;
        tick();
        rst_n = 1'b1; init = 1'b0;
        model_clear();
        chk("abort_valid_drop", 32'(mv_if.move_valid), 32'd0);
        chk("abort_step", 32'(step_count), 32'd0);
        chk("abort_err", 32'(move_err), 32'd0);
        if (use_rst) begin
            chk("rst_move_x", 32'(mv_if.move_x), 32'd0);
            chk("rst_move_y", 32'(mv_if.move_y), 32'd0);
        end
        for (int i = 0; i < 4; i++) begin
            chk("abort_no_fin", 32'(finished_reading), 32'd0);
            tick();
        end
        mv_if.move_ready = 1'b1;
        chk("abort_pop_count", 32'(pop_cnt), 32'(exp_pops));
    endtask

    initial begin
        mv_if.move_ready = 1'b1;
        // Reset held with a live request.
        rst_n = 1'b0;
        read_checkList = 1'b1;
        cl_empty = 1'b0;
        repeat (3) tick();
        chk("rst_cl_pop", 32'(cl_pop), 32'd0);
        chk("rst_fin", 32'(finished_reading), 32'd0);
        chk("rst_valid", 32'(mv_if.move_valid), 32'd0);
        chk("rst_x", 32'(mv_if.move_x), 32'd0);
        chk("rst_y", 32'(mv_if.move_y), 32'd0);
        chk("rst_dir", 32'(mv_if.move_dir), 32'd0);
        chk("rst_step", 32'(step_count), 32'd0);
        chk("rst_path_end", 32'(path_end), 32'd0);
        chk("rst_move_err", 32'(move_err), 32'd0);
        rst_n = 1'b1;
        read_checkList = 1'b0;
        cl_empty = 1'b1;
        model_clear();
        chk("post_rst_no_pop", 32'(cl_pop), 32'd0);
        tick();
        chk("idle_no_pop", 32'(cl_pop), 32'd0);

        // Directed path: right, right, down.
        request(1'b0, 2'b01, 100, 0);
        request(1'b0, 2'b01, 100, 0);
        request(1'b0, 2'b11, 100, 0);
        chk("step_after_three", 32'(step_count), 32'd3);

        // Empty store.
        request(1'b1, 2'b00, 100, 0);

        // Up at origin is blocked.
        do_init();
        chk("init_path_end", 32'(path_end), 32'd0);
        request(1'b0, 2'b00, 100, 0);
        chk("origin_err", 32'(move_err), 32'd1);
        request(1'b0, 2'b10, 100, 0);
        request(1'b0, 2'b11, 100, 0);

        // Back-pressure for 5 cycles.
        request(1'b0, 2'b01, 100, 5);

        // Abort in PRESENT by init, then by reset.
        abort(1'b0, 2'b11);
        abort(1'b1, 2'b01);

        // Random walk, long enough to reach step saturation.
        for (int n = 0; n < 300; n++) begin
            bit emp;
            emp = ($urandom_range(0, 9) == 0);
            request(emp, 2'($urandom), $urandom_range(30, 100), 0);
        end
        chk("step_saturated", 32'(step_count), 32'(m_step));
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
